// File: rtl/general_register_file_decoded.sv
`default_nettype none
// ============================================================================
// Module   : general_register_file_decoded
// Purpose  : Eight x86 general registers with built-in register-code decode,
//            registered read ports and a byte-merging write port with bypass.
// Revision : 1.0  initial release
// ============================================================================
module general_register_file_decoded #(
    parameter int          READ_PORTS    = 2,
    parameter logic [31:0] RESET_EDX     = 32'h0000_0308,
    parameter int          BYPASS_ENABLE = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [READ_PORTS-1:0]      read_valid,
    input  logic [3*READ_PORTS-1:0]    read_code,
    input  logic [READ_PORTS-1:0]      read_w_in_instruction,
    input  logic [READ_PORTS-1:0]      read_w,
    input  logic [READ_PORTS-1:0]      read_operand_size_32,
    output logic [32*READ_PORTS-1:0]   read_data,
    output logic [READ_PORTS-1:0]      read_data_valid,
    input  logic                       write_valid,
    input  logic [2:0]                 write_code,
    input  logic                       write_w_in_instruction,
    input  logic                       write_w,
    input  logic                       write_operand_size_32,
    input  logic [31:0]                write_data,
    output logic [255:0]               register_dump
);

    localparam logic [1:0] c_KIND_LO    = 2'd0;
    localparam logic [1:0] c_KIND_HI    = 2'd1;
    localparam logic [1:0] c_KIND_WORD  = 2'd2;
    localparam logic [1:0] c_KIND_DWORD = 2'd3;

    // Returns {physical register index, access kind}.
    function automatic logic [4:0] decode(input logic       wi,
                                          input logic       w,
                                          input logic       os32,
                                          input logic [2:0] code);
        if (wi && !w)
            decode = {1'b0, code[1:0], (code[2] ? c_KIND_HI : c_KIND_LO)};
        else
            decode = {code, (os32 ? c_KIND_DWORD : c_KIND_WORD)};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] data,
                                          input logic [1:0]  kind);
        case (kind)
            c_KIND_LO:   merge = {old_val[31:8], data[7:0]};
            c_KIND_HI:   merge = {old_val[31:16], data[7:0], old_val[7:0]};
            c_KIND_WORD: merge = {old_val[31:16], data[15:0]};
            default:     merge = data;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] val,
                                            input logic [1:0]  kind);
        case (kind)
            c_KIND_LO:   extract = {24'b0, val[7:0]};
            c_KIND_HI:   extract = {24'b0, val[15:8]};
            c_KIND_WORD: extract = {16'b0, val[15:0]};
            default:     extract = val;
        endcase
    endfunction

    logic [31:0] r_regs [8];
    logic [4:0]  w_wr_dec;
    logic [31:0] w_wr_merged;

    assign w_wr_dec    = decode(write_w_in_instruction, write_w,
                                write_operand_size_32, write_code);
    assign w_wr_merged = merge(r_regs[w_wr_dec[4:2]], write_data, w_wr_dec[1:0]);

    // Reset wins over a simultaneous write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 8; k++)
                r_regs[k] <= (k == 2) ? RESET_EDX : 32'h0;
        end else if (write_valid) begin
            r_regs[w_wr_dec[4:2]] <= w_wr_merged;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < READ_PORTS; gi++) begin : g_read
            logic [4:0]  w_dec;
            logic        w_hit;
            logic [31:0] w_src;
            logic [31:0] r_data;
            logic        r_valid;

            assign w_dec = decode(read_w_in_instruction[gi], read_w[gi],
                                  read_operand_size_32[gi], read_code[3*gi +: 3]);
            assign w_hit = (BYPASS_ENABLE != 0) && write_valid &&
                           (w_dec[4:2] == w_wr_dec[4:2]);
            assign w_src = w_hit ? w_wr_merged : r_regs[w_dec[4:2]];

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_data  <= 32'h0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= read_valid[gi];
                    if (read_valid[gi])
                        r_data <= extract(w_src, w_dec[1:0]);
                end
            end

            assign read_data[32*gi +: 32] = r_data;
            assign read_data_valid[gi]    = r_valid;
        end
    endgenerate

    genvar gj;
    generate
        for (gj = 0; gj < 8; gj++) begin : g_dump
            assign register_dump[32*gj +: 32] = r_regs[gj];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_general_register_file_decoded.sv
`default_nettype none
// ============================================================================
// Module   : tb_general_register_file_decoded
// Purpose  : Scoreboard bench for general_register_file_decoded, bypass on/off.
// Revision : 1.0  initial release
// ============================================================================
module tb_general_register_file_decoded;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   read_valid;
    logic [5:0]   read_code;
    logic [1:0]   read_w_in_instruction;
    logic [1:0]   read_w;
    logic [1:0]   read_operand_size_32;
    logic [63:0]  read_data_b, read_data_n;
    logic [1:0]   read_data_valid_b, read_data_valid_n;
    logic         write_valid;
    logic [2:0]   write_code;
    logic         write_w_in_instruction;
    logic         write_w;
    logic         write_operand_size_32;
    logic [31:0]  write_data;
    logic [255:0] dump_b, dump_n;

    int vectors    = 0;
    int miscompares = 0;
    // Channels 0,1: bypass DUT ports; 2,3: no-bypass DUT ports.
    logic [31:0] q [4][$];

    always #5 clock = ~clock;

    general_register_file_decoded #(.READ_PORTS(2), .BYPASS_ENABLE(1)) dut_b (
        .clock(clock), .reset(reset),
        .read_valid(read_valid), .read_code(read_code),
        .read_w_in_instruction(read_w_in_instruction), .read_w(read_w),
        .read_operand_size_32(read_operand_size_32),
        .read_data(read_data_b), .read_data_valid(read_data_valid_b),
        .write_valid(write_valid), .write_code(write_code),
        .write_w_in_instruction(write_w_in_instruction), .write_w(write_w),
        .write_operand_size_32(write_operand_size_32), .write_data(write_data),
        .register_dump(dump_b));

    general_register_file_decoded #(.READ_PORTS(2), .BYPASS_ENABLE(0)) dut_n (
        .clock(clock), .reset(reset),
        .read_valid(read_valid), .read_code(read_code),
        .read_w_in_instruction(read_w_in_instruction), .read_w(read_w),
        .read_operand_size_32(read_operand_size_32),
        .read_data(read_data_n), .read_data_valid(read_data_valid_n),
        .write_valid(write_valid), .write_code(write_code),
        .write_w_in_instruction(write_w_in_instruction), .write_w(write_w),
        .write_operand_size_32(write_operand_size_32), .write_data(write_data),
        .register_dump(dump_n));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_read(input int p, input logic wi, input logic w, input logic os,
                            input logic [2:0] code, input logic [31:0] eb, input logic [31:0] en);
        read_valid[p]            = 1'b1;
        read_code[3*p +: 3]      = code;
        read_w_in_instruction[p] = wi;
        read_w[p]                = w;
        read_operand_size_32[p]  = os;
        q[p].push_back(eb);
        q[p+2].push_back(en);
    endtask

    task automatic set_write(input logic wi, input logic w, input logic os,
                             input logic [2:0] code, input logic [31:0] data);
        write_valid            = 1'b1;
        write_w_in_instruction = wi;
        write_w                = w;
        write_operand_size_32  = os;
        write_code             = code;
        write_data             = data;
    endtask

    task automatic tick();
        @(negedge clock);
        read_valid  = 2'b00;
        write_valid = 1'b0;
    endtask

    task automatic check_reg(input string name, input int idx, input logic [31:0] exp);
        check({name, "_byp"},   dump_b[32*idx +: 32], exp);
        check({name, "_nobyp"}, dump_n[32*idx +: 32], exp);
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] k;
        k = 8'(i);
        pat = {8'hA0 + k, 8'hB0 + k, 8'hC0 + k, 8'hD0 + k};
    endfunction

    // Spec-level reference for a read with a known pattern in every register.
    function automatic logic [31:0] ref_read(input logic wi, input logic w, input logic os,
                                             input logic [2:0] code);
        logic [31:0] r;
        if (wi && !w) begin
            r = pat(int'(code[1:0]));
            ref_read = code[2] ? {24'b0, r[15:8]} : {24'b0, r[7:0]};
        end else begin
            r = pat(int'(code));
            ref_read = os ? r : {16'b0, r[15:0]};
        end
    endfunction

    always @(negedge clock) begin
        logic        v;
        logic [31:0] d;
        logic [31:0] e;
        for (int c = 0; c < 4; c++) begin
            v = (c < 2) ? read_data_valid_b[c] : read_data_valid_n[c-2];
            d = (c < 2) ? read_data_b[32*c +: 32] : read_data_n[32*(c-2) +: 32];
            if (v === 1'b1) begin
                if (q[c].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_valid ch%0d: got data %h expected no response", c, d);
                end else begin
                    e = q[c].pop_front();
                    check($sformatf("read_ch%0d", c), d, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] c0, c1;
        reset = 1'b1;
        read_valid = '0; read_code = '0; read_w_in_instruction = '0;
        read_w = '0; read_operand_size_32 = '0;
        write_valid = 1'b0; write_code = '0; write_w_in_instruction = 1'b0;
        write_w = 1'b0; write_operand_size_32 = 1'b0; write_data = '0;

        // Reset state
        tick(); tick();
        check_reg("rst_eax", 0, 32'h0);
        check_reg("rst_edx", 2, 32'h0000_0308);
        check_reg("rst_edi", 7, 32'h0);
        check("rst_valid", {30'b0, read_data_valid_b}, 32'h0);
        check("rst_data",  read_data_b[31:0], 32'h0);
        reset = 1'b0;

        // 8-bit AH write and read
        set_write(1'b0, 1'b0, 1'b1, 3'd0, 32'h1122_3344); tick();
        set_write(1'b1, 1'b0, 1'b1, 3'd4, 32'hFFFF_FFAB); tick();
        check_reg("ah_write", 0, 32'h1122_AB44);
        set_read(0, 1'b1, 1'b0, 1'b1, 3'd4, 32'h0000_00AB, 32'h0000_00AB); tick();

        // 16-bit BP write, 32-bit EBP read
        set_write(1'b0, 1'b0, 1'b1, 3'd5, 32'hFFFF_FFFF); tick();
        set_write(1'b0, 1'b0, 1'b0, 3'd5, 32'hDEAD_BEEF); tick();
        check_reg("bp_write", 5, 32'hFFFF_BEEF);
        set_read(0, 1'b0, 1'b0, 1'b1, 3'd5, 32'hFFFF_BEEF, 32'hFFFF_BEEF); tick();

        // Bypass: AL write with same-cycle AX and AH reads
        set_write(1'b0, 1'b0, 1'b1, 3'd0, 32'h1122_3344); tick();
        set_write(1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0077);
        set_read(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0000_3377, 32'h0000_3344);
        set_read(1, 1'b1, 1'b0, 1'b0, 3'd4, 32'h0000_0033, 32'h0000_0033);
        tick();
        check_reg("al_write", 0, 32'h1122_3377);

        // Two ports: CH and ECX together
        set_write(1'b0, 1'b0, 1'b1, 3'd1, 32'hA1B2_C3D4); tick();
        set_read(0, 1'b1, 1'b0, 1'b0, 3'd5, 32'h0000_00C3, 32'h0000_00C3);
        set_read(1, 1'b0, 1'b0, 1'b1, 3'd1, 32'hA1B2_C3D4, 32'hA1B2_C3D4);
        tick();
        check("two_port_valid", {30'b0, read_data_valid_b}, 32'h3);
        tick();
        check("hold_valid", {30'b0, read_data_valid_b}, 32'h0);
        check("hold_data",  read_data_b[63:32], 32'hA1B2_C3D4);

        // Reset mid-operation: write and read in the reset cycle are dropped
        reset = 1'b1;
        set_write(1'b0, 1'b0, 1'b1, 3'd0, 32'hDEAD_DEAD);
        read_valid[0] = 1'b1;
        read_code[2:0] = 3'd1; read_operand_size_32[0] = 1'b1;
        read_w_in_instruction[0] = 1'b0;
        tick();
        reset = 1'b0;
        check_reg("midrst_eax", 0, 32'h0);
        check_reg("midrst_ecx", 1, 32'h0);
        check_reg("midrst_edx", 2, 32'h0000_0308);
        check("midrst_valid", {30'b0, read_data_valid_b}, 32'h0);
        check("midrst_data",  read_data_b[31:0], 32'h0);
        set_read(0, 1'b0, 1'b0, 1'b1, 3'd2, 32'h0000_0308, 32'h0000_0308);
        set_read(1, 1'b1, 1'b0, 1'b0, 3'd6, 32'h0000_0003, 32'h0000_0003);
        tick();

        // Exhaustive decode sweep over a known pattern
        for (int i = 0; i < 8; i++) begin
            set_write(1'b0, 1'b0, 1'b1, 3'(i), pat(i)); tick();
        end
        for (int k = 0; k < 32; k++) begin
            logic [4:0] a, b;
            a  = 5'(k);
            b  = 5'(31 - k);
            c0 = {a[4:3] == 2'b00 ? 1'b0 : 1'b1, a[1:0]};
            c0 = a[2:0];
            c1 = b[2:0];
            set_read(0, a[4], a[3], k[0] ^ a[4], c0,
                     ref_read(a[4], a[3], k[0] ^ a[4], c0),
                     ref_read(a[4], a[3], k[0] ^ a[4], c0));
            set_read(1, b[4], b[3], ~k[0], c1,
                     ref_read(b[4], b[3], ~k[0], c1),
                     ref_read(b[4], b[3], ~k[0], c1));
            tick();
        end
        tick(); tick();
        for (int c = 0; c < 4; c++)
            check($sformatf("queue_empty_ch%0d", c), 32'(q[c].size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
